// File: rtl/ka_24bit_seq.sv
// Sequenced 24-bit carry-less multiplier: one shared 12x12 GF(2) multiplier is reused
// for the low, high and middle Karatsuba sub-products over three cycles.
module ka_24bit_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      a,
    input  logic [23:0]      b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [46:0]      y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [2:0] {StIdle, StMLo, StMHi, StMMid, StDone} state_e;

    state_e      state;
    logic [23:0] a_r, b_r;
    logic [22:0] p_lo, p_hi;
    logic [11:0] mul_x, mul_y;
    logic [22:0] p;
    logic [22:0] mid;
    logic [46:0] y_next;

    function automatic logic [10:0] clmul6(input logic [5:0] x, input logic [5:0] z);
        logic [10:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (z[i]) r ^= 11'(x) << i;
        end
        return r;
    endfunction

    // Shared KA_12bit: itself a one-level Karatsuba split into 6-bit halves
    always_comb begin
        logic [10:0] k_lo, k_hi, k_mm, k_mid;
        k_lo  = clmul6(mul_x[5:0], mul_y[5:0]);
        k_hi  = clmul6(mul_x[11:6], mul_y[11:6]);
        k_mm  = clmul6(mul_x[5:0] ^ mul_x[11:6], mul_y[5:0] ^ mul_y[11:6]);
        k_mid = k_lo ^ k_hi ^ k_mm;
        p     = 23'(k_lo) ^ (23'(k_mid) << 6) ^ (23'(k_hi) << 12);
    end

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        unique case (state)
            StMLo: begin
                mul_x = a_r[11:0];
                mul_y = b_r[11:0];
            end
            StMHi: begin
                mul_x = a_r[23:12];
                mul_y = b_r[23:12];
            end
            StMMid: begin
                mul_x = a_r[11:0] ^ a_r[23:12];
                mul_y = b_r[11:0] ^ b_r[23:12];
            end
            default: ;
        endcase
    end

    // p holds the middle-term product during StMMid
    assign mid    = p_lo ^ p_hi ^ p;
    assign y_next = 47'(p_lo) ^ (47'(mid) << 12) ^ (47'(p_hi) << 24);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            a_r       <= '0;
            b_r       <= '0;
            p_lo      <= '0;
            p_hi      <= '0;
            y         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            op_cnt    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StMLo;
                    end
                end
                StMLo: begin
                    p_lo  <= p;
                    state <= StMHi;
                end
                StMHi: begin
                    p_hi  <= p;
                    state <= StMMid;
                end
                StMMid: begin
                    y         <= y_next;
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        op_cnt    <= op_cnt + CNT_W'(1);
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ka_24bit_seq.sv
// Bench for ka_24bit_seq: directed steps plus a random regression, with expected
// products queued at accept time and compared at each output handshake.
module tb_ka_24bit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [46:0] y;
    logic        out_valid;
    logic        busy;
    logic [15:0] op_cnt;

    int n_pass = 0;
    int n_total = 0;
    int done_ops = 0;
    logic [46:0] exp_q[$];

    ka_24bit_seq #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .op_cnt   (op_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Bit-serial shift-and-xor reference
    function automatic logic [46:0] clmul_ref(input logic [23:0] x, input logic [23:0] z);
        logic [46:0] r;
        r = '0;
        for (int i = 0; i < 24; i++) begin
            if (z[i]) r ^= 47'(x) << i;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] xa, input logic [23:0] xb,
                        input logic [46:0] expv, input bit push);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (in_ready !== 1'b1) check("send_timeout", 64'(in_ready), 64'(1));
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        if (push) exp_q.push_back(expv);
        tick();
        in_valid = 1'b0;
        a        = 24'($urandom);
        b        = 24'($urandom);
    endtask

    task automatic recv(input int stall);
        int t;
        logic [46:0] e;
        if (stall > 0) begin
            out_ready = 1'b0;
            repeat (stall) tick();
        end
        t = 0;
        while (out_valid !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (out_valid !== 1'b1) begin
            check("recv_timeout", 64'(out_valid), 64'(1));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            out_ready = 1'b1;
            return;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 47'h0;
        out_ready = 1'b1;
        check("y", 64'(y), 64'(e));
        tick();
        done_ops++;
    endtask

    initial begin
        logic [46:0] y_hold;
        logic [23:0] xa, xb;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_y", 64'(y), 64'(0));
        check("rst_op_cnt", 64'(op_cnt), 64'(0));

        // Reset while in M_HI discards the operation
        send(24'h00ABCD, 24'h001234, 47'h0, 1'b0);
        tick();
        check("busy_m_hi", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_y", 64'(y), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_op_cnt", 64'(op_cnt), 64'(0));
        repeat (4) tick();
        check("midrst_no_output", 64'(out_valid), 64'(0));

        send(24'h123456, 24'hABCDEF, clmul_ref(24'h123456, 24'hABCDEF), 1'b1);
        recv(0);
        check("op_cnt_after_first", 64'(op_cnt), 64'(done_ops));

        // Latency: out_valid low in cycles 1..3, high in cycle 4
        out_ready = 1'b1;
        send(24'h000001, 24'h000001, 47'h1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            check("lat_early", 64'(out_valid), 64'(0));
            tick();
        end
        check("lat_cycle4", 64'(out_valid), 64'(1));
        check("lat_busy", 64'(busy), 64'(1));
        recv(0);
        check("lat_op_cnt", 64'(op_cnt), 64'(done_ops));
        check("lat_in_ready", 64'(in_ready), 64'(1));

        // Directed products
        send(24'h000003, 24'h000003, 47'h5, 1'b1);
        recv(0);
        send(24'hFFFFFF, 24'h000001, 47'hFFFFFF, 1'b1);
        recv(0);
        send(24'h001000, 24'h001000, 47'h1000000, 1'b1);
        recv(0);
        send(24'h800000, 24'h800000, 47'h4000_0000_0000, 1'b1);
        recv(0);

        // Backpressure: result held 10 cycles, new operands refused
        out_ready = 1'b0;
        send(24'h00F0F5, 24'h0A0007, clmul_ref(24'h00F0F5, 24'h0A0007), 1'b1);
        repeat (3) tick();
        check("bp_out_valid", 64'(out_valid), 64'(1));
        y_hold   = y;
        a        = 24'h777777;
        b        = 24'h333333;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_y_stable", 64'(y), 64'(y_hold));
            check("bp_valid_held", 64'(out_valid), 64'(1));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        recv(0);
        check("bp_idle_busy", 64'(busy), 64'(0));
        check("bp_idle_in_ready", 64'(in_ready), 64'(1));
        check("bp_idle_out_valid", 64'(out_valid), 64'(0));
        check("bp_op_cnt", 64'(op_cnt), 64'(done_ops));

        // Random regression from a clean counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_op_cnt", 64'(op_cnt), 64'(0));
        for (int n = 0; n < 10000; n++) begin
            xa = 24'($urandom);
            xb = 24'($urandom);
            if ($urandom_range(0, 3) == 0) tick();
            send(xa, xb, clmul_ref(xa, xb), 1'b1);
            recv(($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        check("final_op_cnt", 64'(op_cnt), 64'(16'd10000));
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ka_24bit_seq.md
# ka_24bit_seq

Sequenced 24-bit carry-less (GF(2)[x]) polynomial multiplier. It time-shares one combinational `KA_12bit` instance across the three sub-products of a one-level Karatsuba split, which trades three cycles of latency for two-thirds of the multiplier area. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the area-optimised alternative to a fully parallel 24-bit multiplier.

## Interface

- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, synchronous and active-high.
- `a`  input  24  multiplicand polynomial; bit i is the coefficient of x^i.
- `b`  input  24  multiplier polynomial.
- `in_valid`  input  1  operands on `a`/`b` are valid.
- `in_ready`  output  1  block can accept operands.
- `y`  output  47  carry-less product a·b over GF(2).
- `out_valid`  output  1  `y` is valid.
- `out_ready`  input  1  consumer accepts `y`.
- `busy`  output  1  the block is between accept and result handoff.
- `op_cnt`  output  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W.

## Operation

- FSM states: IDLE, M_LO, M_HI, M_MID, DONE.
- **IDLE:** `in_ready`=1.
  - On `in_valid & in_ready`, register `a` and `b` into `a_r` and `b_r`, then go to M_LO.
- **Shared multiplier operand mux** (single `KA_12bit`, 23-bit output `p`):
  - M_LO: `a_r[11:0]`, `b_r[11:0]`. Store `p` in `p_lo`.
  - M_HI: `a_r[23:12]`, `b_r[23:12]`. Store `p` in `p_hi`.
  - M_MID: `a_r[11:0]^a_r[23:12]`, `b_r[11:0]^b_r[23:12]`. Use `p` directly in the recombination.
  - IDLE/DONE: drive zeros to the mux.
- **Recombination** at the end of M_MID; the result is registered into `y`:
  - `mid = p_lo ^ p_hi ^ p` (23 bits).
  - `y = {24'b0,p_lo} ^ ({24'b0,mid} << 12) ^ ({24'b0,p_hi} << 24)`, truncated to 47 bits. Bit 46 can only come from `p_hi`.
  - All arithmetic is XOR. There are no carries.
- After M_MID, go to DONE.
- **DONE:** `out_valid`=1 and `y` is held stable.
  - On `out_ready`, go to IDLE and increment `op_cnt`.
- `busy` = (state != IDLE).
- `in_ready` is high only in IDLE. There is no overlap of a new accept with a pending result.
- Do not touch `a_r`/`b_r` except on accept. Inputs may change freely after accept.
- Once asserted, `out_valid` stays high until the handshake completes.

## Timing

- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `y`=0, `op_cnt`=0. `p_lo`, `p_hi`, `a_r` and `b_r` clear to 0.
- **Reset mid-operation** (any state): the block returns to IDLE on the next edge, and the in-flight operation is discarded with no output handshake. `rst` overrides any simultaneous `in_valid` or `out_ready`.
- **Latency:** the accept edge is at cycle 0.
  - M_LO occupies cycle 1, M_HI cycle 2 and M_MID cycle 3.
  - `out_valid` rises after the edge ending cycle 3, so it is visible in cycle 4.
  - With `out_ready` held at 1, back-to-back operations start every 5 cycles: accept, 3 multiply cycles, handoff.
- **Handshake:** a transfer occurs on a rising edge where valid & ready are both 1. Valid must not depend combinationally on ready, and ready must not depend combinationally on valid.
- **Counter:** `op_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- **Critical path:** `a_r` → XOR pre-add → `KA_12bit` → 3-way XOR → `y` register. There is no combinational path from input ports to output ports.

## Test plan

- a=1, b=1 with `out_ready`=1 → `out_valid` in cycle 4 after accept, `y`=47'h1, `op_cnt`=1.
- a=24'h000003, b=24'h000003 → `y`=47'h5, i.e. (x+1)²=x²+1 with no carry. Then a=24'hFFFFFF, b=1 → `y`=47'hFFFFFF.
- Middle-term and top-bit check: a=b=24'h001000 → `y`=47'h1000000 (x^24). Then a=b=24'h800000 → `y`=47'h4000_0000_0000 (bit 46 set).
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `y` and `out_valid` stay stable and `in_ready`=0. A new `in_valid` during this time is not accepted. After `out_ready`=1 for one edge, the block is in IDLE.
- Assert `rst` in M_HI → next cycle the state is IDLE, with `out_valid`=0, `y`=0 and `op_cnt` unchanged. A following operation a=24'h123456, b=24'hABCDEF matches a bit-serial carry-less reference model.
- Random regression: 10k random operand pairs with random `in_valid`/`out_ready` gaps, each result checked against the software carry-less model. Finish with `op_cnt`=10000 mod 2^16.
